// File: rtl/axil2cpu_bridge.sv
// axil2cpu_bridge
//   AXI4-Lite slave that turns host register accesses into the single-cycle
//   cpu_wr / cpu_rd register bus of the user register file. One transaction
//   is executed at a time. Each of the AW, W and AR channels has a depth-1
//   buffer.
//
// Ports
//   clks, reset_n                      clock, asynchronous active-low reset
//   aw*/w*/b*                          AXI4-Lite write address/data/response
//   ar*/r*                             AXI4-Lite read address/response
//   cpu_wr, cpu_wr_addr, cpu_data_in   register-file write strobe, word address
//                                      (shared with reads), write data
//   cpu_rd, cpu_data_out               register-file read strobe, registered
//                                      read data (valid RD_LATENCY cycles later)
//   dbg_state                          current FSM state encoding
//
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. A source holds valid and its payload
// stable until that edge. Readies here only reflect buffer emptiness, and
// bvalid/rvalid stay high with a stable payload until the matching ready.
module axil2cpu_bridge #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int RD_LATENCY     = 1
) (
  input  logic                          clks,
  input  logic                          reset_n,
  input  logic                          awvalid,
  output logic                          awready,
  input  logic [AXI_ADDR_WIDTH-1:0]     awaddr,
  input  logic                          wvalid,
  output logic                          wready,
  input  logic [CPU_DATA_WIDTH-1:0]     wdata,
  input  logic [CPU_DATA_WIDTH/8-1:0]   wstrb,
  output logic                          bvalid,
  input  logic                          bready,
  output logic [1:0]                    bresp,
  input  logic                          arvalid,
  output logic                          arready,
  input  logic [AXI_ADDR_WIDTH-1:0]     araddr,
  output logic                          rvalid,
  input  logic                          rready,
  output logic [CPU_DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                    rresp,
  output logic                          cpu_wr,
  output logic [CPU_ADDR_WIDTH-1:0]     cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0]     cpu_data_in,
  output logic                          cpu_rd,
  input  logic [CPU_DATA_WIDTH-1:0]     cpu_data_out,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_EXEC = 3'd1,
    WR_RESP = 3'd2,
    RD_EXEC = 3'd3,
    RD_WAIT = 3'd4,
    RD_RESP = 3'd5
  } state_e;

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

  state_e                        state_q;
  logic                          last_wr_q;
  logic [2:0]                    lat_cnt_q;
  logic                          aw_full_q, w_full_q, ar_full_q;
  logic                          aw_full_d, w_full_d, ar_full_d;
  logic [AXI_ADDR_WIDTH-1:0]     aw_addr_q, ar_addr_q;
  logic [CPU_DATA_WIDTH-1:0]     w_data_q;
  logic [CPU_DATA_WIDTH/8-1:0]   w_strb_q;
  logic                          awready_q, wready_q, arready_q;
  logic                          bvalid_q, rvalid_q, cpu_wr_q, cpu_rd_q;
  logic [1:0]                    bresp_q, rresp_q;
  logic [CPU_DATA_WIDTH-1:0]     rdata_q, cpu_data_in_q;
  logic [CPU_ADDR_WIDTH-1:0]     cpu_wr_addr_q;

  logic aw_take, w_take, ar_take;
  logic aw_free, w_free, ar_free;
  logic aw_oor, ar_oor, strb_ok;
  logic wr_elig, rd_elig, grant_wr, grant_rd;
  logic [CPU_ADDR_WIDTH-1:0] aw_word, ar_word;

  always_comb begin
    aw_take = awvalid & awready_q;
    w_take  = wvalid  & wready_q;
    ar_take = arvalid & arready_q;
    // Write buffers are released after the execute cycle; AR is held until
    // the read response is accepted so no new read can be buffered behind it.
    aw_free = (state_q == WR_EXEC);
    w_free  = (state_q == WR_EXEC);
    ar_free = (state_q == RD_RESP) & rready;
    aw_full_d = (aw_full_q & ~aw_free) | aw_take;
    w_full_d  = (w_full_q  & ~w_free)  | w_take;
    ar_full_d = (ar_full_q & ~ar_free) | ar_take;
    // Any address bit above the word-address field means out of range.
    aw_oor  = |(aw_addr_q >> (CPU_ADDR_WIDTH + 2));
    ar_oor  = |(ar_addr_q >> (CPU_ADDR_WIDTH + 2));
    aw_word = aw_addr_q[CPU_ADDR_WIDTH+1:2];
    ar_word = ar_addr_q[CPU_ADDR_WIDTH+1:2];
    strb_ok = (w_strb_q == '1);
    wr_elig = aw_full_q & w_full_q;
    rd_elig = ar_full_q;
    // On a tie, alternate against the last granted type.
    grant_wr = wr_elig & (~rd_elig | ~last_wr_q);
    grant_rd = rd_elig & ~grant_wr;
  end

  // Channel buffers and their readies (ready = buffer empty next cycle).
  always_ff @(posedge clks or negedge reset_n) begin
    if (!reset_n) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      ar_full_q <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      aw_addr_q <= '0;
      ar_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      ar_full_q <= ar_full_d;
      awready_q <= ~aw_full_d;
      wready_q  <= ~w_full_d;
      arready_q <= ~ar_full_d;
      if (aw_take) aw_addr_q <= awaddr;
      if (ar_take) ar_addr_q <= araddr;
      if (w_take) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Transaction FSM. Strobes are set on the grant so they are high exactly
  // during the EXEC cycle; the bus address/data only change on a real access.
  always_ff @(posedge clks or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_wr_q     <= 1'b0;
      lat_cnt_q     <= '0;
      bvalid_q      <= 1'b0;
      bresp_q       <= 2'b00;
      rvalid_q      <= 1'b0;
      rresp_q       <= 2'b00;
      rdata_q       <= '0;
      cpu_wr_q      <= 1'b0;
      cpu_rd_q      <= 1'b0;
      cpu_wr_addr_q <= '0;
      cpu_data_in_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            state_q   <= WR_EXEC;
            last_wr_q <= 1'b1;
            if (!aw_oor && strb_ok) begin
              cpu_wr_q      <= 1'b1;
              cpu_wr_addr_q <= aw_word;
              cpu_data_in_q <= w_data_q;
            end
          end else if (grant_rd) begin
            state_q   <= RD_EXEC;
            last_wr_q <= 1'b0;
            if (!ar_oor) begin
              cpu_rd_q      <= 1'b1;
              cpu_wr_addr_q <= ar_word;
            end
          end
        end
        WR_EXEC: begin
          cpu_wr_q <= 1'b0;
          bvalid_q <= 1'b1;
          // Out of range wins over a partial strobe.
          bresp_q  <= aw_oor ? 2'b11 : (strb_ok ? 2'b00 : 2'b10);
          state_q  <= WR_RESP;
        end
        WR_RESP: begin
          if (bready) begin
            bvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        RD_EXEC: begin
          cpu_rd_q  <= 1'b0;
          lat_cnt_q <= '0;
          if (ar_oor) begin
            rvalid_q <= 1'b1;
            rdata_q  <= '0;
            rresp_q  <= 2'b11;
            state_q  <= RD_RESP;
          end else begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (lat_cnt_q == LAT_LAST) begin
            rdata_q  <= cpu_data_out;
            rresp_q  <= 2'b00;
            rvalid_q <= 1'b1;
            state_q  <= RD_RESP;
          end else begin
            lat_cnt_q <= lat_cnt_q + 3'd1;
          end
        end
        RD_RESP: begin
          if (rready) begin
            rvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign awready     = awready_q;
  assign wready      = wready_q;
  assign arready     = arready_q;
  assign bvalid      = bvalid_q;
  assign bresp       = bresp_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign rresp       = rresp_q;
  assign cpu_wr      = cpu_wr_q;
  assign cpu_rd      = cpu_rd_q;
  assign cpu_wr_addr = cpu_wr_addr_q;
  assign cpu_data_in = cpu_data_in_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_axil2cpu_bridge.sv
`timescale 1ns/1ps
module tb_axil2cpu_bridge;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (RD_LATENCY = 1) ----------------
  logic        awvalid = 0, awready;
  logic [15:0] awaddr = 0;
  logic        wvalid = 0, wready;
  logic [31:0] wdata = 0;
  logic [3:0]  wstrb = 0;
  logic        bvalid, bready = 0;
  logic [1:0]  bresp;
  logic        arvalid = 0, arready;
  logic [15:0] araddr = 0;
  logic        rvalid, rready = 0;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        cpu_wr, cpu_rd;
  logic [11:0] cpu_wr_addr;
  logic [31:0] cpu_data_in, cpu_data_out;
  logic [2:0]  dbg_state;

  axil2cpu_bridge #(.AXI_ADDR_WIDTH(16), .CPU_ADDR_WIDTH(12), .CPU_DATA_WIDTH(32), .RD_LATENCY(1)) u_dut (
    .clks(clk), .reset_n(reset_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .cpu_wr(cpu_wr), .cpu_wr_addr(cpu_wr_addr), .cpu_data_in(cpu_data_in),
    .cpu_rd(cpu_rd), .cpu_data_out(cpu_data_out), .dbg_state(dbg_state)
  );

  // ---------------- DUT (RD_LATENCY = 3), read side only ----------------
  logic        awready3, wready3, bvalid3, cpu_wr3;
  logic [1:0]  bresp3;
  logic [31:0] cpu_data_in3;
  logic        arvalid3 = 0, arready3;
  logic [15:0] araddr3 = 0;
  logic        rvalid3, rready3 = 0;
  logic [31:0] rdata3;
  logic [1:0]  rresp3;
  logic        cpu_rd3;
  logic [11:0] cpu_wr_addr3;
  logic [31:0] cpu_data_out3;
  logic [2:0]  dbg_state3;

  axil2cpu_bridge #(.AXI_ADDR_WIDTH(16), .CPU_ADDR_WIDTH(12), .CPU_DATA_WIDTH(32), .RD_LATENCY(3)) u_dut3 (
    .clks(clk), .reset_n(reset_n),
    .awvalid(1'b0), .awready(awready3), .awaddr(16'h0),
    .wvalid(1'b0), .wready(wready3), .wdata(32'h0), .wstrb(4'h0),
    .bvalid(bvalid3), .bready(1'b1), .bresp(bresp3),
    .arvalid(arvalid3), .arready(arready3), .araddr(araddr3),
    .rvalid(rvalid3), .rready(rready3), .rdata(rdata3), .rresp(rresp3),
    .cpu_wr(cpu_wr3), .cpu_wr_addr(cpu_wr_addr3), .cpu_data_in(cpu_data_in3),
    .cpu_rd(cpu_rd3), .cpu_data_out(cpu_data_out3), .dbg_state(dbg_state3)
  );

  // ---------------- register-file model ----------------
  // Data is only valid exactly RD_LATENCY cycles after cpu_rd; other cycles
  // carry a poison word so a mistimed capture shows up.
  logic [31:0] mem [0:4095];
  logic [31:0] pipe1 = 32'hDEADBEEF;
  logic [31:0] pipe3 [3] = '{default: 32'hDEADBEEF};
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[1] = 32'h00D30008;
  end
  always @(posedge clk) begin
    if (cpu_wr) mem[cpu_wr_addr] <= cpu_data_in;
    pipe1    <= cpu_rd  ? mem[cpu_wr_addr]  : 32'hDEADBEEF;
    pipe3[0] <= cpu_rd3 ? mem[cpu_wr_addr3] : 32'hDEADBEEF;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign cpu_data_out  = pipe1;
  assign cpu_data_out3 = pipe3[2];

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // ---------------- scoreboard / bus monitor ----------------
  logic [43:0] exp_q[$];     // {word address, data} of expected cpu writes
  logic [43:0] exp_e;
  int          wr_cnt = 0, rd_cnt = 0, rd3_cnt = 0;
  int          wr_cyc = 0, rd_cyc = 0, rd3_cyc = 0;
  logic [11:0] rd_addr = 0, rd3_addr = 0;
  logic        prev_wr = 0, prev_rd = 0, prev_rd3 = 0;

  always @(negedge clk) begin
    if (cpu_wr) begin
      wr_cnt++;
      wr_cyc = cyc;
      exp_e = (exp_q.size() > 0) ? exp_q.pop_front() : {12'hFFF, 32'hDEADDEAD};
      check("cpu_wr_addr", 32'(cpu_wr_addr), 32'(exp_e[43:32]));
      check("cpu_data_in", cpu_data_in, exp_e[31:0]);
      check("cpu_wr_single_cycle", 32'(prev_wr), 32'h0);
    end
    if (cpu_rd) begin
      rd_cnt++;
      rd_cyc  = cyc;
      rd_addr = cpu_wr_addr;
      check("cpu_rd_without_wr", 32'(cpu_wr), 32'h0);
      check("cpu_rd_single_cycle", 32'(prev_rd), 32'h0);
    end
    if (cpu_rd3) begin
      rd3_cnt++;
      rd3_cyc  = cyc;
      rd3_addr = cpu_wr_addr3;
      check("cpu_rd3_single_cycle", 32'(prev_rd3), 32'h0);
    end
    prev_wr  = cpu_wr;
    prev_rd  = cpu_rd;
    prev_rd3 = cpu_rd3;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic axi_write(input logic [15:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input bit do_aw, input bit do_w);
    bit a_hs, w_hs;
    @(posedge clk); #1;
    awvalid = do_aw; awaddr = addr;
    wvalid  = do_w;  wdata  = data; wstrb = strb;
    for (int i = 0; i < 40 && (awvalid || wvalid); i++) begin
      @(negedge clk);
      a_hs = awvalid && awready;
      w_hs = wvalid && wready;
      @(posedge clk); #1;
      if (a_hs) awvalid = 0;
      if (w_hs) wvalid = 0;
    end
    if (awvalid || wvalid) begin
      check("wr_handshake_timeout", 32'({awready, wready}), 32'({awvalid, wvalid}));
      awvalid = 0;
      wvalid  = 0;
    end
  endtask

  task automatic wait_b(input logic [1:0] exp_resp, input string tag);
    bit seen = 0;
    @(posedge clk); #1;
    bready = 1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (bvalid) begin
        check({tag, "_bresp"}, 32'(bresp), 32'(exp_resp));
        seen = 1;
      end
      @(posedge clk); #1;
    end
    bready = 0;
    if (!seen) check({tag, "_b_timeout"}, 32'(bvalid), 32'h1);
    else begin
      @(negedge clk);
      check({tag, "_b_drop"}, 32'(bvalid), 32'h0);
    end
  endtask

  // exp_lat = cycles from the cpu_rd cycle to the rvalid cycle; 0 means no
  // cpu_rd is expected at all.
  task automatic axi_read(input bit d3, input logic [15:0] addr, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp, input int exp_lat,
                          input logic [11:0] exp_word, input string tag);
    bit seen = 0;
    bit hs;
    int rc0;
    rc0 = d3 ? rd3_cnt : rd_cnt;
    @(posedge clk); #1;
    if (d3) begin arvalid3 = 1; araddr3 = addr; rready3 = 1; end
    else    begin arvalid  = 1; araddr  = addr; rready  = 1; end
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      hs = d3 ? (arvalid3 && arready3) : (arvalid && arready);
      if (d3 ? rvalid3 : rvalid) begin
        seen = 1;
        check({tag, "_rdata"}, d3 ? rdata3 : rdata, exp_data);
        check({tag, "_rresp"}, 32'(d3 ? rresp3 : rresp), 32'(exp_resp));
        if (exp_lat > 0) begin
          check({tag, "_latency"}, 32'(cyc - (d3 ? rd3_cyc : rd_cyc)), 32'(exp_lat));
          check({tag, "_cpu_addr"}, 32'(d3 ? rd3_addr : rd_addr), 32'(exp_word));
        end
      end
      @(posedge clk); #1;
      if (hs) begin
        if (d3) arvalid3 = 0; else arvalid = 0;
      end
    end
    if (d3) begin rready3 = 0; arvalid3 = 0; end
    else    begin rready  = 0; arvalid  = 0; end
    if (!seen) check({tag, "_r_timeout"}, 32'(d3 ? rvalid3 : rvalid), 32'h1);
    check({tag, "_rd_strobes"}, 32'((d3 ? rd3_cnt : rd_cnt) - rc0), (exp_lat > 0) ? 32'h1 : 32'h0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish within 200us");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int  base;
  bit  seen;

  initial begin
    // reset state
    reset_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_readies", 32'({awready, wready, arready}), 32'h0);
    check("rst_resp_valid", 32'({bvalid, rvalid}), 32'h0);
    check("rst_resp_codes", 32'({bresp, rresp}), 32'h0);
    check("rst_strobes", 32'({cpu_wr, cpu_rd}), 32'h0);
    check("rst_cpu_addr", 32'(cpu_wr_addr), 32'h0);
    check("rst_cpu_data", cpu_data_in, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(posedge clk); #1 reset_n = 1;
    @(negedge clk);
    check("readies_before_first_clk", 32'({awready, wready, arready}), 32'h0);
    @(negedge clk);
    check("readies_after_first_clk", 32'({awready, wready, arready}), 32'h7);

    // full write, AW and W together
    base = wr_cnt;
    exp_q.push_back({12'h002, 32'h12345678});
    axi_write(16'h0008, 32'h12345678, 4'hF, 1, 1);
    wait_b(2'b00, "full_wr");
    check("full_wr_count", 32'(wr_cnt - base), 32'h1);

    // W three cycles before AW
    base = wr_cnt;
    axi_write(16'h0000, 32'hCAFEF00D, 4'hF, 0, 1);
    @(posedge clk);
    @(negedge clk);
    check("wfirst_wready_low", 32'(wready), 32'h0);
    check("wfirst_no_wr_yet", 32'(wr_cnt - base), 32'h0);
    exp_q.push_back({12'h006, 32'hCAFEF00D});
    axi_write(16'h0018, 32'h0, 4'h0, 1, 0);
    wait_b(2'b00, "wfirst");
    check("wfirst_count", 32'(wr_cnt - base), 32'h1);

    // reads at RD_LATENCY 1 and 3
    axi_read(0, 16'h0004, 32'h00D30008, 2'b00, 2, 12'h001, "rd_lat1");
    axi_read(1, 16'h0004, 32'h00D30008, 2'b00, 4, 12'h001, "rd_lat3");

    // error responses
    base = wr_cnt;
    axi_write(16'h0010, 32'h55555555, 4'h3, 1, 1);
    wait_b(2'b10, "err_strb");
    axi_write(16'h4000, 32'h66666666, 4'hF, 1, 1);
    wait_b(2'b11, "err_oor_wr");
    axi_write(16'h4000, 32'h77777777, 4'h3, 1, 1);
    wait_b(2'b11, "err_oor_over_strb");
    check("err_no_cpu_wr", 32'(wr_cnt - base), 32'h0);
    axi_read(0, 16'h8000, 32'h0, 2'b11, 0, 12'h000, "err_oor_rd");

    // simultaneous AW/W/AR: write must land before the read sees the word
    exp_q.push_back({12'h003, 32'hA5A50001});
    fork
      begin
        axi_write(16'h000C, 32'hA5A50001, 4'hF, 1, 1);
        wait_b(2'b00, "arb_wr");
      end
      axi_read(0, 16'h000C, 32'hA5A50001, 2'b00, 2, 12'h003, "arb_rd");
    join
    check("arb_wr_before_rd", 32'(wr_cyc < rd_cyc), 32'h1);

    // bready stall with a second write queued
    base = wr_cnt;
    exp_q.push_back({12'h008, 32'h11111111});
    exp_q.push_back({12'h009, 32'h22222222});
    axi_write(16'h0020, 32'h11111111, 4'hF, 1, 1);
    for (int i = 0; i < 10 && !bvalid; i++) @(negedge clk);
    check("stall_bvalid_up", 32'(bvalid), 32'h1);
    axi_write(16'h0024, 32'h22222222, 4'hF, 1, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_bvalid_held", 32'(bvalid), 32'h1);
      check("stall_awready_low", 32'({awready, wready}), 32'h0);
      check("stall_single_wr", 32'(wr_cnt - base), 32'h1);
    end
    wait_b(2'b00, "stall_b1");
    wait_b(2'b00, "stall_b2");
    check("stall_total_wr", 32'(wr_cnt - base), 32'h2);

    // reset asserted while the latency-3 instance is in RD_WAIT
    base = rd3_cnt;
    @(posedge clk); #1;
    arvalid3 = 1; araddr3 = 16'h0004; rready3 = 1;
    @(negedge clk);
    check("rst_rd_arready", 32'(arready3), 32'h1);
    @(posedge clk); #1 arvalid3 = 0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (rd3_cnt != base) seen = 1;
    end
    check("rst_rd_cpu_rd_seen", 32'(rd3_cnt - base), 32'h1);
    @(negedge clk);
    check("rst_rd_in_wait", 32'(dbg_state3), 32'h4);
    #2 reset_n = 0;
    #1;
    check("midrst_rvalid", 32'({rvalid3, rvalid}), 32'h0);
    check("midrst_cpu_rd", 32'({cpu_rd3, cpu_rd}), 32'h0);
    check("midrst_readies", 32'({arready3, awready, wready, arready}), 32'h0);
    check("midrst_state", 32'(dbg_state3), 32'h0);
    rready3 = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    axi_read(1, 16'h0004, 32'h00D30008, 2'b00, 4, 12'h001, "rd_after_rst");

    // wrap-up
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    check("total_cpu_wr", 32'(wr_cnt), 32'h5);
    check("total_cpu_rd", 32'(rd_cnt), 32'h2);
    check("final_state_idle", 32'(dbg_state), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
